// File: rtl/atahost_pio_seq.sv
// rtl/atahost_pio_seq.sv - PIO ATA bus cycle sequencer (setup/strobe/IORDY wait/recovery)
// Optional IORDY watchdog: define ATAHOST_PIO_IORDY_TIMEOUT_EN.
module atahost_pio_seq #(
  parameter int          TWIDTH    = 8,
  parameter logic [15:0] IORDY_TMO = 16'hFFFF
) (
  input  logic              wb_clk_i,
  input  logic              arst_signal,
  input  logic              rst,
  input  logic              en,
  input  logic              req,
  input  logic              we,
  input  logic [3:0]        a,
  input  logic [15:0]       d,
  input  logic [TWIDTH-1:0] T1,
  input  logic [TWIDTH-1:0] T2,
  input  logic [TWIDTH-1:0] T4,
  input  logic [TWIDTH-1:0] Teoc,
  input  logic              iordy_en,
  output logic              ack,
  output logic [15:0]       q,
  output logic              busy,
  output logic              err,
  output logic              DIORn,
  output logic              DIOWn,
  output logic [2:0]        DA,
  output logic              CS0n,
  output logic              CS1n,
  input  logic [15:0]       DDi,
  output logic [15:0]       DDo,
  output logic              DDoe,
  input  logic              IORDY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_RECOVER
  } state_t;

  state_t            state;
  logic [TWIDTH-1:0] cnt;
  logic [TWIDTH-1:0] hold;
  logic [TWIDTH-1:0] t2_r;
  logic [TWIDTH-1:0] t4_r;
  logic [TWIDTH-1:0] teoc_r;
  logic              we_r;
  logic              iordy_m;
  logic              iordy_s;
  logic              end_now;
  logic              tmo_hit;

`ifdef ATAHOST_PIO_IORDY_TIMEOUT_EN
  logic [15:0] wd;
  logic        err_r;

  assign tmo_hit = (state == S_WAIT) && !iordy_s && (wd == IORDY_TMO - 16'd1);
  assign err     = err_r;
`else
  logic unused_tmo;

  assign unused_tmo = ^IORDY_TMO;
  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
`endif

  // IORDY is fully asynchronous to wb_clk_i; idle level is "ready".
  always_ff @(posedge wb_clk_i or negedge arst_signal) begin
    if (!arst_signal) begin
      iordy_m <= 1'b1;
      iordy_s <= 1'b1;
    end else if (rst) begin
      iordy_m <= 1'b1;
      iordy_s <= 1'b1;
    end else begin
      iordy_m <= IORDY;
      iordy_s <= iordy_m;
    end
  end

  // END is not a state of its own: it is the exit edge of STROBE or WAIT.
  always_comb begin
    end_now = 1'b0;
    if (state == S_STROBE && cnt == '0 && !(iordy_en && !iordy_s))
      end_now = 1'b1;
    if (state == S_WAIT && (iordy_s || tmo_hit))
      end_now = 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge arst_signal) begin
    if (!arst_signal) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hold   <= '0;
      t2_r   <= '0;
      t4_r   <= '0;
      teoc_r <= '0;
      we_r   <= 1'b0;
      ack    <= 1'b0;
      q      <= 16'h0000;
      busy   <= 1'b0;
      DIORn  <= 1'b1;
      DIOWn  <= 1'b1;
      DA     <= 3'd0;
      CS0n   <= 1'b1;
      CS1n   <= 1'b1;
      DDo    <= 16'h0000;
      DDoe   <= 1'b0;
`ifdef ATAHOST_PIO_IORDY_TIMEOUT_EN
      wd     <= 16'h0000;
      err_r  <= 1'b0;
`endif
    end else if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hold   <= '0;
      t2_r   <= '0;
      t4_r   <= '0;
      teoc_r <= '0;
      we_r   <= 1'b0;
      ack    <= 1'b0;
      q      <= 16'h0000;
      busy   <= 1'b0;
      DIORn  <= 1'b1;
      DIOWn  <= 1'b1;
      DA     <= 3'd0;
      CS0n   <= 1'b1;
      CS1n   <= 1'b1;
      DDo    <= 16'h0000;
      DDoe   <= 1'b0;
`ifdef ATAHOST_PIO_IORDY_TIMEOUT_EN
      wd     <= 16'h0000;
      err_r  <= 1'b0;
`endif
    end else begin
      ack <= 1'b0;
`ifdef ATAHOST_PIO_IORDY_TIMEOUT_EN
      err_r <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (req && en) begin
            we_r   <= we;
            DA     <= a[2:0];
            CS0n   <= a[3];
            CS1n   <= ~a[3];
            cnt    <= T1;
            t2_r   <= T2;
            t4_r   <= T4;
            teoc_r <= Teoc;
            busy   <= 1'b1;
            state  <= S_SETUP;
            if (we) begin
              DDo  <= d;
              DDoe <= 1'b1;
            end
          end
        end

        S_SETUP: begin
          if (cnt == '0) begin
            if (we_r)
              DIOWn <= 1'b0;
            else
              DIORn <= 1'b0;
            cnt   <= t2_r;
            state <= S_STROBE;
          end else begin
            cnt <= cnt - TWIDTH'(1);
          end
        end

        S_STROBE: begin
          if (cnt != '0) begin
            cnt <= cnt - TWIDTH'(1);
          end else if (!end_now) begin
            state <= S_WAIT;
`ifdef ATAHOST_PIO_IORDY_TIMEOUT_EN
            wd    <= 16'h0000;
`endif
          end
        end

        S_WAIT: begin
`ifdef ATAHOST_PIO_IORDY_TIMEOUT_EN
          if (!end_now)
            wd <= wd + 16'd1;
`endif
        end

        S_RECOVER: begin
          // Hold window never outlasts recovery, since recovery is max(Teoc,T4).
          if (hold == '0)
            DDoe <= 1'b0;
          else
            hold <= hold - TWIDTH'(1);
          if (cnt == '0) begin
            CS0n  <= 1'b1;
            CS1n  <= 1'b1;
            DDoe  <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - TWIDTH'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (end_now) begin
        DIORn <= 1'b1;
        DIOWn <= 1'b1;
        ack   <= 1'b1;
        if (!we_r)
          q <= tmo_hit ? 16'hFFFF : DDi;
        cnt   <= (teoc_r > t4_r) ? teoc_r : t4_r;
        hold  <= t4_r;
        state <= S_RECOVER;
`ifdef ATAHOST_PIO_IORDY_TIMEOUT_EN
        err_r <= tmo_hit;
`endif
      end
    end
  end

endmodule

// File: tb/tb_atahost_pio_seq.sv
// tb/tb_atahost_pio_seq.sv - directed self-checking bench for atahost_pio_seq
module tb_atahost_pio_seq;

  logic        clk = 1'b0;
  logic        arst_signal, rst, en, req, we, iordy_en, IORDY;
  logic [3:0]  a;
  logic [15:0] d, DDi;
  logic [7:0]  T1, T2, T4, Teoc;
  logic        ack, busy, err, DIORn, DIOWn, CS0n, CS1n, DDoe;
  logic [15:0] q, DDo;
  logic [2:0]  DA;

  int checks = 0;
  int failures = 0;
  int ack_at;

  always #5 clk = ~clk;

  atahost_pio_seq #(.TWIDTH(8), .IORDY_TMO(16'd20)) dut (
    .wb_clk_i(clk), .arst_signal(arst_signal), .rst(rst), .en(en), .req(req),
    .we(we), .a(a), .d(d), .T1(T1), .T2(T2), .T4(T4), .Teoc(Teoc),
    .iordy_en(iordy_en), .ack(ack), .q(q), .busy(busy), .err(err),
    .DIORn(DIORn), .DIOWn(DIOWn), .DA(DA), .CS0n(CS0n), .CS1n(CS1n),
    .DDi(DDi), .DDo(DDo), .DDoe(DDoe), .IORDY(IORDY)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_t(input logic [7:0] t1, input logic [7:0] t2,
                       input logic [7:0] t4, input logic [7:0] teoc);
    T1 = t1; T2 = t2; T4 = t4; Teoc = teoc;
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    arst_signal = 1'b0; rst = 1'b0; en = 1'b0; req = 1'b0; we = 1'b0;
    a = 4'h0; d = 16'h0; DDi = 16'h0; iordy_en = 1'b0; IORDY = 1'b1;
    set_t(8'd0, 8'd0, 8'd0, 8'd0);
    tick(); tick();
    chk("rst_diorn", DIORn, 1); chk("rst_diown", DIOWn, 1);
    chk("rst_cs0n", CS0n, 1);   chk("rst_cs1n", CS1n, 1);
    chk("rst_da", DA, 0);       chk("rst_ddo", DDo, 0);
    chk("rst_ddoe", DDoe, 0);   chk("rst_ack", ack, 0);
    chk("rst_q", q, 0);         chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    arst_signal = 1'b1;
    tick();

    // Read, T1=2 T2=3 T4=1 Teoc=4: strobe k+3..k+7, ack at k+7, idle at k+12
    en = 1'b1; we = 1'b0; a = 4'h7; DDi = 16'h1111;
    set_t(8'd2, 8'd3, 8'd1, 8'd4);
    req = 1'b1;
    tick();
    chk("t1_cs0n", CS0n, 0); chk("t1_cs1n", CS1n, 1);
    chk("t1_da", DA, 7);     chk("t1_busy", busy, 1); chk("t1_ddoe", DDoe, 0);
    set_t(8'd9, 8'd9, 8'd9, 8'd9);
    for (int n = 1; n <= 12; n++) begin
      if (n == 7) DDi = 16'h1234;
      tick();
      chk("t1_diorn", DIORn, (n >= 3 && n <= 6) ? 0 : 1);
      chk("t1_ack", ack, (n == 7) ? 1 : 0);
      chk("t1_busy_n", busy, (n < 12) ? 1 : 0);
      chk("t1_cs0n_n", CS0n, (n < 12) ? 0 : 1);
      if (n == 7) begin
        DDi = 16'hBEEF;
        req = 1'b0;
      end
    end
    chk("t1_q", q, 16'h1234); chk("t1_da_hold", DA, 7);

    // Write to CS1, DA=6: DDoe held until k+9
    we = 1'b1; a = 4'hE; d = 16'hA55A;
    set_t(8'd2, 8'd3, 8'd1, 8'd4);
    req = 1'b1;
    tick();
    chk("t2_cs1n", CS1n, 0); chk("t2_cs0n", CS0n, 1); chk("t2_da", DA, 6);
    chk("t2_ddoe", DDoe, 1); chk("t2_ddo", DDo, 16'hA55A);
    for (int n = 1; n <= 12; n++) begin
      tick();
      chk("t2_diown", DIOWn, (n >= 3 && n <= 6) ? 0 : 1);
      chk("t2_diorn", DIORn, 1);
      chk("t2_ddoe_n", DDoe, (n < 9) ? 1 : 0);
      chk("t2_ack", ack, (n == 7) ? 1 : 0);
      if (n == 7) req = 1'b0;
    end
    chk("t2_q", q, 16'h1234); chk("t2_busy", busy, 0);

    // All-zero timings, req held: 4-clock cadence, one ack per access
    we = 1'b0; a = 4'h0; DDi = 16'h5A5A;
    set_t(8'd0, 8'd0, 8'd0, 8'd0);
    req = 1'b1;
    tick();
    chk("t3_diorn0", DIORn, 1);
    for (int n = 1; n <= 15; n++) begin
      tick();
      chk("t3_diorn", DIORn, (n % 4 == 1) ? 0 : 1);
      chk("t3_ack", ack, (n % 4 == 2) ? 1 : 0);
    end
    req = 1'b0;
    tick();
    chk("t3_busy", busy, 0); chk("t3_q", q, 16'h5A5A);

    // en low blocks acceptance
    en = 1'b0; req = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      tick();
      chk("en0_busy", busy, 0);
    end
    req = 1'b0;

    // IORDY low at strobe expiry, released after edge k+11 -> strobe ends at k+14;
    // en dropped mid-cycle must not abort the cycle
    en = 1'b1; iordy_en = 1'b1; IORDY = 1'b0; DDi = 16'h0C0C;
    tick(); tick(); tick();
    req = 1'b1;
    tick();
    en = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      chk("t4_diorn", DIORn, (n <= 13) ? 0 : 1);
      chk("t4_ack", ack, (n == 14) ? 1 : 0);
      if (n == 11) IORDY = 1'b1;
      if (n == 14) begin
        chk("t4_err", err, 0);
        req = 1'b0;
      end
    end
    chk("t4_q", q, 16'h0C0C); chk("t4_busy", busy, 0);
    en = 1'b1; iordy_en = 1'b0;

    // Sync reset during STROBE of a write aborts without ack
    we = 1'b1; a = 4'h0; d = 16'h1357;
    set_t(8'd0, 8'd5, 8'd3, 8'd3);
    req = 1'b1;
    tick(); tick();
    chk("t5_diown_low", DIOWn, 0); chk("t5_ddoe_on", DDoe, 1);
    rst = 1'b1;
    tick();
    chk("t5_diown", DIOWn, 1); chk("t5_cs0n", CS0n, 1); chk("t5_ddoe", DDoe, 0);
    chk("t5_busy", busy, 0);   chk("t5_ack", ack, 0);   chk("t5_ddo", DDo, 0);
    rst = 1'b0; req = 1'b0;
    tick();
    we = 1'b0; a = 4'h9; DDi = 16'h2468;
    set_t(8'd1, 8'd1, 8'd1, 8'd1);
    req = 1'b1;
    tick();
    chk("t5_cs1n", CS1n, 0); chk("t5_da", DA, 1);
    ack_at = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (ack && ack_at == 0) begin
        ack_at = n;
        req = 1'b0;
      end
    end
    chk("t5_ack_at", ack_at, 4); chk("t5_q", q, 16'h2468);

`ifdef ATAHOST_PIO_IORDY_TIMEOUT_EN
    // IORDY stuck low: WAIT entered at k+2, watchdog ends cycle 20 clocks later
    iordy_en = 1'b1; IORDY = 1'b0; DDi = 16'h7777;
    set_t(8'd0, 8'd0, 8'd0, 8'd0);
    tick(); tick(); tick();
    req = 1'b1;
    tick();
    for (int n = 1; n <= 24; n++) begin
      tick();
      chk("t6_diorn", DIORn, (n <= 21) ? 0 : 1);
      chk("t6_ack", ack, (n == 22) ? 1 : 0);
      chk("t6_err", err, (n == 22) ? 1 : 0);
      if (n == 22) req = 1'b0;
    end
    chk("t6_q", q, 16'hFFFF);
    IORDY = 1'b1; iordy_en = 1'b0;
`else
    chk("err_tied", err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atahost_pio_seq.md
Name: atahost_pio_seq

Overview:
PIO-compatible ATA bus cycle sequencer that sits directly downstream of the host register/bus-interface stage. It accepts one 16-bit PIO register access request at a time, carrying the programmed T1/T2/T4/Teoc timing values. It drives DA, CS0n/CS1n, DIORn/DIOWn and the DD bus with cycle-accurate timing, honours IORDY, and returns read data plus a one-cycle acknowledge.

Parameters:
TWIDTH, 8, width of timing inputs and internal timing counter
IORDY_TMO, 16'hFFFF, IORDY-wait watchdog limit in clocks (used only with the optional feature)

Ports:
wb_clk_i  in  1  master clock
arst_signal  in  1  asynchronous reset, active-low
rst  in  1  synchronous reset, active-high
en  in  1  controller enable; new requests are accepted only when high
req  in  1  PIO access request; held high until ack
we  in  1  1=write, 0=read; valid with req
a  in  4  a[3]=1 selects CS1n, a[3]=0 selects CS0n; a[2:0] drives DA
d  in  16  write data
T1,T2,T4,Teoc  in  TWIDTH each  timing counts, sampled when a request is accepted
iordy_en  in  1  enable IORDY-extended strobe
ack  out  1  single-cycle completion pulse
q  out  16  read data, registered
busy  out  1  high whenever state is not IDLE
err  out  1  IORDY timeout pulse (tied 0 without the optional feature)
DIORn, DIOWn  out  1 each  read/write strobes
DA  out  3  device address
CS0n, CS1n  out  1 each  chip selects
DDi  in  16  device data in
DDo  out  16  device data out
DDoe  out  1  DD output enable
IORDY  in  1  asynchronous device ready

Behaviour:
- Reset is decided as follows: arst_signal is asynchronous and active-low; the clock is wb_clk_i. Sync rst has identical effect.
- Reset values: DIORn=1, DIOWn=1, CS0n=1, CS1n=1, DA=0, DDo=0, DDoe=0, ack=0, q=0, busy=0, err=0; state=IDLE; IORDY synchroniser=1.
- All outputs are registered. IORDY passes through a 2-flop synchroniser (iordy_s) before use.
- A phase programmed with count N lasts N+1 clocks; N=0 gives 1 clock.
- The active T1/T2/T4/Teoc values are latched at acceptance. Later input changes do not affect the cycle in progress.
- States:
  IDLE: if req&en, latch we/a/d/timings, drive DA and the selected CSn, and load the counter with T1. Go to SETUP. For a write, drive DDo=d and DDoe=1 at the same edge.
  SETUP: count down. At zero, assert DIORn (read) or DIOWn (write) low, load T2, and go to STROBE.
  STROBE: count down. At zero, if iordy_en & !iordy_s, go to WAIT with the strobe held. Otherwise go to END.
  WAIT: hold the strobe. When iordy_s=1, go to END.
  END (a single edge, merged into the STROBE/WAIT exit): negate the strobe. On a read, q<=DDi sampled at this edge. Pulse ack. Load the recovery counter with max(Teoc,T4) and the hold counter with T4. Go to RECOVER.
  RECOVER: DDoe drops when the hold counter expires (after T4+1 clocks). At recovery expiry, CS0n=CS1n=1, DA holds its value, and the state goes to IDLE.
- The earliest next acceptance is the edge after RECOVER expires. A req still high during RECOVER (the requester dropping req after ack) is not re-accepted as a new cycle, because acceptance happens only in IDLE.
- If en falls mid-cycle, the cycle completes normally. While en=0, no new request is accepted.
- rst or arst mid-cycle aborts immediately to reset values, with no ack.
- ack is never high for two consecutive clocks.

Optional Feature:
ATAHOST_PIO_IORDY_TIMEOUT_EN:
- Defined: a 16-bit watchdog counts clocks in WAIT. On reaching IORDY_TMO, the strobe is forced high and the cycle proceeds as END with ack and a one-cycle err pulse. On a read, q=16'hFFFF.
- Undefined: WAIT persists indefinitely, and err is tied to 0.

Test Plan:
1. Read, T1=2, T2=3, T4=1, Teoc=4, a=4'h7, iordy_en=0, req accepted at edge k -> CS0n=0, DA=7 from k; DIORn low edges k+3..k+7; q=DDi(k+7); ack high one clock after k+7; busy low from k+12.
2. Write, a=4'hE, d=16'hA55A, same timings -> CS1n=0, DA=6, DDoe=1, DDo=A55A from k; DIOWn low k+3..k+7; DDoe drops at k+9; ack once; no change on q.
3. All timings 0, back-to-back reads with req held -> each cycle is 1 SETUP + 1 STROBE + 1 RECOVER clock; exactly one ack per access; no overlap of strobes.
4. iordy_en=1, IORDY low before STROBE expiry, released 10 clocks later -> strobe extended by 10 clocks plus 2 synchroniser clocks; then normal END/ack.
5. Assert rst in STROBE -> next edge DIORn=1, CSn=1, DDoe=0, busy=0, no ack; a fresh req completes normally.
6. With ATAHOST_PIO_IORDY_TIMEOUT_EN, IORDY_TMO=20, IORDY stuck low -> after 20 WAIT clocks, strobe negates, ack and err pulse together, q=FFFF.
